dcache_ctrl: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache controller.
- Sits between the core's load/store unit and the memory bus. Owns the tag/valid array.
- Sequences four external 8-bit byte-block banks (one per byte lane, asynchronous read, write on rising clk_i when write enable is high) through shared bank address/data/enable lines.
- Runs line refills on read misses, write-throughs on every store, and a full-cache invalidate sweep.

---
 rtl/dcache_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dcache_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Define DCACHE_PERF_CNT_EN to add the hit/miss counter ports.
module dcache_ctrl #(
   parameter int INDEX_BITS = 4,
   parameter int WOFF_BITS  = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic                            cpu_valid_i,
   input  logic                            cpu_we_i,
   input  logic [31:0]                     cpu_addr_i,
   input  logic [31:0]                     cpu_wdata_i,
   input  logic [3:0]                      cpu_wstrb_i,
   output logic                            cpu_ready_o,
   output logic [31:0]                     cpu_rdata_o,
   input  logic                            flush_i,
   output logic                            busy_o,
   output logic [INDEX_BITS+WOFF_BITS-1:0] bank_addr_o,
   output logic [31:0]                     bank_wdata_o,
   output logic [3:0]                      bank_we_o,
   input  logic [31:0]                     bank_rdata_i,
   output logic                            mem_req_o,
   output logic                            mem_we_o,
   output logic [31:0]                     mem_addr_o,
   output logic [31:0]                     mem_wdata_o,
   output logic [3:0]                      mem_wstrb_o,
   input  logic                            mem_ack_i,
   input  logic [31:0]                     mem_rdata_i
`ifdef DCACHE_PERF_CNT_EN
   ,
   output logic [31:0]                     hit_cnt_o,
   output logic [31:0]                     miss_cnt_o
`endif
);

   localparam int BANK_AW   = INDEX_BITS + WOFF_BITS;
   localparam int TAG_BITS  = 32 - INDEX_BITS - WOFF_BITS - 2;
   localparam int LINE_BITS = TAG_BITS + INDEX_BITS;
   localparam int LINES     = 1 << INDEX_BITS;

   typedef enum logic [1:0] {IDLE, REFILL, WTHRU, FLUSH} state_t;

   state_t                state_q, state_d;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_ram [LINES];
   logic [LINE_BITS-1:0]  line_q;
   logic [WOFF_BITS-1:0]  rcnt_q, rcnt_d;
   logic [INDEX_BITS-1:0] fcnt_q, fcnt_d;
   logic [INDEX_BITS-1:0] idx, line_idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit, ld_hit, ld_miss, fill;
   logic                  addr_unused;

   assign addr_unused = ^cpu_addr_i[1:0];
   assign idx      = cpu_addr_i[BANK_AW+1 -: INDEX_BITS];
   assign tag      = cpu_addr_i[31 -: TAG_BITS];
   assign line_idx = line_q[INDEX_BITS-1:0];
   assign hit      = valid_q[idx] && (tag_ram[idx] == tag);

   // Request decode shared by the FSM and the perf counters
   assign ld_hit  = !rst_i && (state_q == IDLE) && !flush_i &&
                    cpu_valid_i && !cpu_we_i && hit;
   assign ld_miss = !rst_i && (state_q == IDLE) && !flush_i &&
                    cpu_valid_i && !cpu_we_i && !hit;

   always_comb begin
      state_d      = state_q;
      rcnt_d       = rcnt_q;
      fcnt_d       = fcnt_q;
      fill         = 1'b0;
      cpu_ready_o  = 1'b0;
      cpu_rdata_o  = '0;
      busy_o       = 1'b0;
      bank_addr_o  = '0;
      bank_wdata_o = '0;
      bank_we_o    = '0;
      mem_req_o    = 1'b0;
      mem_we_o     = 1'b0;
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      mem_wstrb_o  = '0;
      if (!rst_i) begin
         busy_o = (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               bank_addr_o = cpu_addr_i[BANK_AW+1:2];
               if (flush_i) begin
                  state_d = FLUSH;
                  fcnt_d  = '0;
               end else if (cpu_valid_i && cpu_we_i) begin
                  state_d = WTHRU;
               end else if (ld_hit) begin
                  cpu_ready_o = 1'b1;
                  cpu_rdata_o = bank_rdata_i;
               end else if (ld_miss) begin
                  state_d = REFILL;
                  rcnt_d  = '0;
               end
            end
            REFILL: begin
               mem_req_o   = 1'b1;
               mem_addr_o  = {line_q, rcnt_q, 2'b00};
               bank_addr_o = {line_idx, rcnt_q};
               if (mem_ack_i) begin
                  bank_wdata_o = mem_rdata_i;
                  bank_we_o    = 4'hF;
                  rcnt_d       = rcnt_q + 1'b1;
                  if (rcnt_q == '1) begin
                     fill    = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
            WTHRU: begin
               mem_req_o   = 1'b1;
               mem_we_o    = 1'b1;
               mem_addr_o  = {cpu_addr_i[31:2], 2'b00};
               mem_wdata_o = cpu_wdata_i;
               mem_wstrb_o = cpu_wstrb_i;
               bank_addr_o = cpu_addr_i[BANK_AW+1:2];
               if (mem_ack_i) begin
                  cpu_ready_o = 1'b1;
                  state_d     = IDLE;
                  if (hit) begin
                     bank_we_o    = cpu_wstrb_i;
                     bank_wdata_o = cpu_wdata_i;
                  end
               end
            end
            FLUSH: begin
               fcnt_d = fcnt_q + 1'b1;
               if (fcnt_q == '1)
                  state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         valid_q <= '0;
         line_q  <= '0;
         rcnt_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
         fcnt_q  <= fcnt_d;
         if (ld_miss)
            line_q <= cpu_addr_i[31 -: LINE_BITS];
         // Line only becomes valid once its last word has landed
         if (fill)
            valid_q[line_idx] <= 1'b1;
         else if (state_q == FLUSH)
            valid_q[fcnt_q] <= 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (fill)
         tag_ram[line_idx] <= line_q[LINE_BITS-1 -: TAG_BITS];
   end

`ifdef DCACHE_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_o  <= '0;
         miss_cnt_o <= '0;
      end else begin
         if (ld_hit)
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if (ld_miss)
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with byte-bank and bus memory models.
// Memory acks each request after two cycles of mem_req_o.
module tb_dcache_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cpu_valid_i, cpu_we_i;
   logic [31:0] cpu_addr_i, cpu_wdata_i;
   logic [3:0]  cpu_wstrb_i;
   logic        cpu_ready_o;
   logic [31:0] cpu_rdata_o;
   logic        flush_i, busy_o;
   logic [5:0]  bank_addr_o;
   logic [31:0] bank_wdata_o, bank_rdata_i;
   logic [3:0]  bank_we_o;
   logic        mem_req_o, mem_we_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_wstrb_o;
`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst_i),
      .cpu_valid_i(cpu_valid_i), .cpu_we_i(cpu_we_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_wstrb_i(cpu_wstrb_i), .cpu_ready_o(cpu_ready_o),
      .cpu_rdata_o(cpu_rdata_o), .flush_i(flush_i), .busy_o(busy_o),
      .bank_addr_o(bank_addr_o), .bank_wdata_o(bank_wdata_o),
      .bank_we_o(bank_we_o), .bank_rdata_i(bank_rdata_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_wstrb_o(mem_wstrb_o), .mem_ack_i(mem_ack_i),
      .mem_rdata_i(mem_rdata_i)
`ifdef DCACHE_PERF_CNT_EN
      , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Four byte banks, asynchronous read
   logic [7:0] bank [4][64];
   always @(posedge clk)
      for (int k = 0; k < 4; k++)
         if (bank_we_o[k]) bank[k][bank_addr_o] <= bank_wdata_o[8*k +: 8];
   assign bank_rdata_i = {bank[3][bank_addr_o], bank[2][bank_addr_o],
                          bank[1][bank_addr_o], bank[0][bank_addr_o]};

   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_log [$];
   int          rd_cnt = 0, wr_cnt = 0, rd_we_f = 0, wait_c = 0;
   logic [31:0] last_wr_addr, last_wr_data;
   logic [3:0]  last_wr_strb, last_wr_bank_we;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
   endfunction

   // Bus memory responder
   initial begin
      logic [31:0] w;
      mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      last_wr_bank_we = '0;
      forever begin
         @(negedge clk);
         mem_ack_i = 1'b0;
         if (rst_i || !mem_req_o) wait_c = 0;
         else begin
            wait_c++;
            if (wait_c == 2) begin
               wait_c = 0;
               mem_ack_i = 1'b1;
               if (mem_we_o) begin
                  w = mem_rd(mem_addr_o);
                  for (int k = 0; k < 4; k++)
                     if (mem_wstrb_o[k]) w[8*k +: 8] = mem_wdata_o[8*k +: 8];
                  mem[mem_addr_o] = w;
                  last_wr_addr = mem_addr_o;
                  last_wr_data = mem_wdata_o;
                  last_wr_strb = mem_wstrb_o;
                  wr_cnt++;
               end else begin
                  mem_rdata_i = mem_rd(mem_addr_o);
                  rd_log.push_back(mem_addr_o);
                  rd_cnt++;
               end
               #1;
               if (mem_we_o) last_wr_bank_we = bank_we_o;
               else if (bank_we_o == 4'hF) rd_we_f++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cpu_start(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      cpu_valid_i = 1'b1;
      cpu_we_i    = we;
      cpu_addr_i  = a;
      cpu_wdata_i = d;
      cpu_wstrb_i = s;
   endtask

   task automatic cpu_wait(output logic [31:0] rd, output int cyc);
      cyc = 1;
      #1;
      while (cpu_ready_o !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         #1;
         cyc++;
      end
      check("ready_in_time", 32'(cyc < 200), 32'd1);
      rd = cpu_rdata_o;
      @(negedge clk);
      cpu_valid_i = 1'b0;
      cpu_we_i    = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int          cyc, base, wbase, fbase, n;
      mem[32'h40] = 32'h11;
      mem[32'h44] = 32'h22;
      mem[32'h48] = 32'h33;
      mem[32'h4C] = 32'h44;
      rst_i = 1'b1;
      cpu_valid_i = 1'b0; cpu_we_i = 1'b0;
      cpu_addr_i = '0; cpu_wdata_i = '0; cpu_wstrb_i = '0;
      flush_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy_o, 0);
      check("rst_req", mem_req_o, 0);
      check("rst_bank_we", bank_we_o, 0);
      rst_i = 1'b0;
      #1;
      check("idle_busy", busy_o, 0);
      check("idle_ready", cpu_ready_o, 0);
`ifdef DCACHE_PERF_CNT_EN
      check("rst_hit_cnt", hit_cnt_o, 0);
      check("rst_miss_cnt", miss_cnt_o, 0);
`endif

      // Cold load
      base = rd_cnt; fbase = rd_we_f;
      cpu_start(1'b0, 32'h40, '0, '0);
      cpu_wait(rd, cyc);
      check("cold_rdata", rd, 32'h11);
      check("cold_cycles", cyc, 10);
      check("cold_reads", rd_cnt - base, 4);
      check("cold_bank_we_f", rd_we_f - fbase, 4);
      for (int i = 0; i < 4; i++)
         check("cold_addr", rd_log[base+i], 32'h40 + 32'(4*i));

      base = rd_cnt;
      cpu_start(1'b0, 32'h4C, '0, '0);
      cpu_wait(rd, cyc);
      check("hit_rdata", rd, 32'h44);
      check("hit_cycles", cyc, 1);
      check("hit_no_req", rd_cnt - base, 0);
`ifdef DCACHE_PERF_CNT_EN
      check("hit_cnt", hit_cnt_o, 2);
      check("miss_cnt", miss_cnt_o, 1);
`endif

      // Store hit, partial strobe
      wbase = wr_cnt;
      cpu_start(1'b1, 32'h44, 32'hAABB_CCDD, 4'b0011);
      cpu_wait(rd, cyc);
      check("sthit_cycles", cyc, 3);
      check("sthit_writes", wr_cnt - wbase, 1);
      check("sthit_addr", last_wr_addr, 32'h44);
      check("sthit_data", last_wr_data, 32'hAABB_CCDD);
      check("sthit_strb", last_wr_strb, 4'b0011);
      check("sthit_bank_we", last_wr_bank_we, 4'b0011);
      base = rd_cnt;
      cpu_start(1'b0, 32'h44, '0, '0);
      cpu_wait(rd, cyc);
      check("sthit_merge", rd, 32'h0000_CCDD);
      check("sthit_reload_cyc", cyc, 1);
      check("sthit_no_req", rd_cnt - base, 0);

      // Store miss does not allocate
      wbase = wr_cnt;
      cpu_start(1'b1, 32'h1000, 32'h1234_5678, 4'hF);
      cpu_wait(rd, cyc);
      check("stmiss_writes", wr_cnt - wbase, 1);
      check("stmiss_bank_we", last_wr_bank_we, 4'h0);
      base = rd_cnt;
      cpu_start(1'b0, 32'h1000, '0, '0);
      cpu_wait(rd, cyc);
      check("stmiss_refill", rd_cnt - base, 4);
      check("stmiss_rdata", rd, 32'h1234_5678);

      // Conflict on index 4
      cpu_start(1'b0, 32'h40, '0, '0);
      cpu_wait(rd, cyc);
      check("conf_hit_cyc", cyc, 1);
      cpu_start(1'b0, 32'h440, '0, '0);
      cpu_wait(rd, cyc);
      check("conf_b_cyc", cyc, 10);
      check("conf_b_rdata", rd, 32'h5A5A_0440);
      cpu_start(1'b0, 32'h40, '0, '0);
      cpu_wait(rd, cyc);
      check("conf_a_cyc", cyc, 10);
      check("conf_a_rdata", rd, 32'h11);

      // Flush beats a simultaneous hit
      @(negedge clk);
      flush_i = 1'b1;
      cpu_valid_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h4C;
      #1;
      check("flush_no_ack", cpu_ready_o, 0);
      @(negedge clk);
      flush_i = 1'b0;
      #1;
      n = 0;
      while (busy_o && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("flush_busy_cyc", n, 16);
      base = rd_cnt;
      cpu_wait(rd, cyc);
      check("flush_refill", rd_cnt - base, 4);
      check("flush_rdata", rd, 32'h44);
      base = rd_cnt;
      cpu_start(1'b0, 32'h1000, '0, '0);
      cpu_wait(rd, cyc);
      check("flush_l0_miss", rd_cnt - base, 4);

      // Reset in the middle of a refill
      base = rd_cnt;
      cpu_start(1'b0, 32'h80, '0, '0);
      n = 0;
      while (rd_cnt < base + 2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_partial", rd_cnt - base, 2);
      @(negedge clk);
      rst_i = 1'b1;
      cpu_valid_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b0;
      #1;
      check("mid_req_drop", mem_req_o, 0);
      check("mid_busy", busy_o, 0);
`ifdef DCACHE_PERF_CNT_EN
      check("mid_hit_cnt", hit_cnt_o, 0);
      check("mid_miss_cnt", miss_cnt_o, 0);
`endif
      base = rd_cnt;
      cpu_start(1'b0, 32'h80, '0, '0);
      cpu_wait(rd, cyc);
      check("retry_reads", rd_cnt - base, 4);
      check("retry_cycles", cyc, 10);
      check("retry_rdata", rd, 32'h5A5A_0080);
      cpu_start(1'b0, 32'h84, '0, '0);
      cpu_wait(rd, cyc);
      check("retry_hit", rd, 32'h5A5A_0084);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
